// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, constants and stage-1 payload for the FP add aligner
package fp_pkg;
   localparam int EXP_W = 8;
   localparam int FRAC_W = 23;
   localparam int MANT_W = 28;
   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
   localparam int BIAS = 127;
   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [MANT_W-2:0] ml;
      logic [MANT_W-2:0] ms;
      logic              eff_sub;
      logic              special;
      logic              nan;
   } s1_t;
endpackage

// File: rtl/fp_add_align_if.sv
// fp_add_align_if: operand/result handshake bundle for fp_add_align
// master drives operands and out_ready; slave (the aligner) drives in_ready and results
interface fp_add_align_if;
   import fp_pkg::*;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       a;
   logic [31:0]       b;
   logic              sub;
   logic              out_valid;
   logic              out_ready;
   logic              out_sign;
   logic [EXP_W-1:0]  out_exp;
   logic [MANT_W-1:0] out_mant;
   logic              out_special;
   logic              out_nan;
   modport master (output in_valid, a, b, sub, out_ready,
                   input in_ready, out_valid, out_sign, out_exp, out_mant, out_special, out_nan);
   modport slave  (input in_valid, a, b, sub, out_ready,
                   output in_ready, out_valid, out_sign, out_exp, out_mant, out_special, out_nan);
endinterface

// File: rtl/shift_right_sticky.sv
// shift_right_sticky: 27-bit right shift that ORs every lost bit into bit 0
// din: value, amt: shift amount, sat: shift >= 27 (only sticky survives), dout: result
module shift_right_sticky (
   input  logic [26:0] din,
   input  logic [4:0]  amt,
   input  logic        sat,
   output logic [26:0] dout
);
   logic [26:0] sh;
   logic [26:0] mask;
   assign sh = din >> amt;
   assign mask = (27'd1 << amt) - 27'd1;
   assign dout = sat ? {26'd0, |din} : {sh[26:1], sh[0] | (|(din & mask))};
endmodule

// File: rtl/fp_add_align.sv
// fp_add_align: two-stage single-precision add/sub front end (swap, align, add)
// clk/clrn: clock and async active-low reset; io: operand and result handshakes
// out_mant = {carry, hidden, frac, guard, round, sticky} for the leading-one normaliser
module fp_add_align
   import fp_pkg::*;
(
   input logic           clk,
   input logic           clrn,
   fp_add_align_if.slave io
);
   logic              v1, v2, adv2;
   s1_t               s1, p;
   logic              sb, a_big, sl, ss, a_max, b_max;
   logic [30:0]       l, s;
   logic [EXP_W-1:0]  el, es, d;
   logic [MANT_W-2:0] ml, ms, ms_sh;
   logic [MANT_W-1:0] sum;
   assign sb = io.b[31] ^ io.sub;
   // raw magnitude bits order exactly like the values; ties keep a as the larger
   assign a_big = io.a[30:0] >= io.b[30:0];
   assign l = a_big ? io.a[30:0] : io.b[30:0];
   assign s = a_big ? io.b[30:0] : io.a[30:0];
   assign sl = a_big ? io.a[31] : sb;
   assign ss = a_big ? sb : io.a[31];
   assign el = (|l[30:23]) ? l[30:23] : 8'd1;
   assign es = (|s[30:23]) ? s[30:23] : 8'd1;
   assign ml = {|l[30:23], l[22:0], 3'b000};
   assign ms = {|s[30:23], s[22:0], 3'b000};
   assign d = el - es;
   shift_right_sticky u_sh (.din(ms), .amt(d[4:0]), .sat(d >= 8'd27), .dout(ms_sh));
   assign a_max = io.a[30:23] == EXP_MAX;
   assign b_max = io.b[30:23] == EXP_MAX;
   assign p = '{sign: sl, exp: el, ml: ml, ms: ms_sh, eff_sub: sl ^ ss, special: a_max | b_max,
                nan: (a_max & |io.a[22:0]) | (b_max & |io.b[22:0]) | (a_max & b_max & (io.a[31] ^ sb))};
   assign sum = s1.eff_sub ? {1'b0, s1.ml} - {1'b0, s1.ms} : {1'b0, s1.ml} + {1'b0, s1.ms};
   assign adv2 = !v2 | io.out_ready;
   assign io.in_ready = !v1 | adv2;
   assign io.out_valid = v2;
   always_ff @(posedge clk or negedge clrn)
      if (!clrn) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         s1 <= '0;
         io.out_sign <= 1'b0;
         io.out_exp <= '0;
         io.out_mant <= '0;
         io.out_special <= 1'b0;
         io.out_nan <= 1'b0;
      end else begin
         if (io.in_ready) begin
            v1 <= io.in_valid;
            if (io.in_valid) s1 <= p;
         end
         if (adv2) begin
            v2 <= v1;
            if (v1) begin
               io.out_sign <= !s1.special && s1.eff_sub && sum == '0 ? 1'b0 : s1.sign;
               io.out_exp <= s1.exp;
               io.out_mant <= s1.special ? '0 : sum;
               io.out_special <= s1.special;
               io.out_nan <= s1.nan;
            end
         end
      end
endmodule

// File: tb/tb_fp_add_align.sv
// tb_fp_add_align: directed vectors, backpressure/reset sequences and randomized streaming for fp_add_align
module tb_fp_add_align;
   typedef struct {
      logic        sign;
      logic [7:0]  exp;
      logic [27:0] mant;
      logic        sp;
      logic        nan;
   } res_t;
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      res_t        r;
   } vec_t;
   logic clk = 1'b0;
   logic clrn;
   int total = 0;
   int bad = 0;
   res_t q[$];
   logic hold = 1'b0;
   logic [39:0] saved;
   vec_t tv[13];
   fp_add_align_if bus();
   fp_add_align dut (.clk(clk), .clrn(clrn), .io(bus));
   always #5 clk = ~clk;

   task automatic chk(string n, logic [63:0] got, logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", n, got, want);
      end
   endtask

   function automatic res_t model(logic [31:0] a, logic [31:0] b, logic s);
      res_t r;
      logic sa, sbb, sl;
      int ea, eb, xa, xb, xl, xs, d;
      longint ma, mb, ml, ms, al, sum;
      sa = a[31];
      sbb = b[31] ^ s;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      if (ea == 255 || eb == 255) begin
         r.sp = 1'b1;
         r.nan = (ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) || (ea == 255 && eb == 255 && sa != sbb);
         r.sign = ea == 255 ? sa : sbb;
         r.exp = 8'hFF;
         r.mant = 28'd0;
         return r;
      end
      ma = (longint'(ea != 0 ? 1 << 23 : 0) + longint'(a[22:0])) * 8;
      mb = (longint'(eb != 0 ? 1 << 23 : 0) + longint'(b[22:0])) * 8;
      xa = ea == 0 ? 1 : ea;
      xb = eb == 0 ? 1 : eb;
      if (b[30:0] > a[30:0]) begin
         ml = mb; ms = ma; xl = xb; xs = xa; sl = sbb;
      end else begin
         ml = ma; ms = mb; xl = xa; xs = xb; sl = sa;
      end
      d = xl - xs;
      if (d >= 27) al = longint'(ms != 0);
      else al = (ms >> d) | longint'((ms % (longint'(1) << d)) != 0);
      sum = (sa == sbb) ? ml + al : ml - al;
      r.sp = 1'b0;
      r.nan = 1'b0;
      r.exp = 8'(xl);
      r.mant = 28'(sum);
      r.sign = (sa != sbb && sum == 0) ? 1'b0 : sl;
      return r;
   endfunction

   task automatic check_out(string t, res_t e);
      chk({t, " exp"}, 64'(bus.out_exp), 64'(e.exp));
      chk({t, " mant"}, 64'(bus.out_mant), 64'(e.mant));
      chk({t, " special"}, 64'(bus.out_special), 64'(e.sp));
      chk({t, " nan"}, 64'(bus.out_nan), 64'(e.nan));
      if (!e.nan) chk({t, " sign"}, 64'(bus.out_sign), 64'(e.sign));
   endtask

   function automatic logic [31:0] rnd_op(logic [7:0] near);
      logic [7:0] e;
      logic [22:0] f;
      int r;
      r = int'($urandom_range(0, 9));
      e = r == 0 ? 8'd0 : r == 1 ? 8'hFF : r < 6 ? 8'(near + 8'($urandom_range(0, 6)) - 8'd3) : 8'($urandom_range(0, 254));
      f = ($urandom_range(0, 5) == 0) ? 23'd0 : 23'($urandom);
      return {1'($urandom), e, f};
   endfunction

   task automatic tick(output logic acc);
      logic emit;
      #1;
      chk("in_ready", 64'(bus.in_ready), 64'((q.size() < 2) || bus.out_ready));
      emit = bus.out_valid && bus.out_ready;
      acc = bus.in_valid && bus.in_ready;
      if (emit) begin
         chk("sb_nonempty", 64'(q.size() > 0), 64'd1);
         if (q.size() > 0) check_out("stream", q.pop_front());
      end
      if (acc) q.push_back(model(bus.a, bus.b, bus.sub));
      hold = bus.out_valid && !bus.out_ready;
      saved = {bus.out_valid, bus.out_sign, bus.out_exp, bus.out_mant, bus.out_special, bus.out_nan};
      @(negedge clk);
      if (hold) chk("hold", 64'({bus.out_valid, bus.out_sign, bus.out_exp, bus.out_mant, bus.out_special, bus.out_nan}), 64'(saved));
   endtask

   initial begin
      logic acc;
      int idx;
      logic [31:0] bp[3];
      tv[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, '{1'b0, 8'h7F, 28'h8000000, 1'b0, 1'b0}};
      tv[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, '{1'b0, 8'h7F, 28'h0000000, 1'b0, 1'b0}};
      tv[2]  = '{32'h3F800000, 32'h30800000, 1'b0, '{1'b0, 8'h7F, 28'h4000001, 1'b0, 1'b0}};
      tv[3]  = '{32'h7F800000, 32'h7F800000, 1'b1, '{1'b0, 8'hFF, 28'h0000000, 1'b1, 1'b1}};
      tv[4]  = '{32'h7F800000, 32'h3F800000, 1'b0, '{1'b0, 8'hFF, 28'h0000000, 1'b1, 1'b0}};
      tv[5]  = '{32'h40000000, 32'h3F800000, 1'b1, '{1'b0, 8'h80, 28'h2000000, 1'b0, 1'b0}};
      tv[6]  = '{32'h3F800000, 32'h40000000, 1'b1, '{1'b1, 8'h80, 28'h2000000, 1'b0, 1'b0}};
      tv[7]  = '{32'h00000001, 32'h00000001, 1'b0, '{1'b0, 8'h01, 28'h0000010, 1'b0, 1'b0}};
      tv[8]  = '{32'h3F800000, 32'h3F000000, 1'b0, '{1'b0, 8'h7F, 28'h6000000, 1'b0, 1'b0}};
      tv[9]  = '{32'h3F800000, 32'h32800001, 1'b1, '{1'b0, 8'h7F, 28'h3FFFFFF, 1'b0, 1'b0}};
      tv[10] = '{32'hBF800000, 32'h3F800000, 1'b0, '{1'b0, 8'h7F, 28'h0000000, 1'b0, 1'b0}};
      tv[11] = '{32'hFF800000, 32'h3F800000, 1'b0, '{1'b1, 8'hFF, 28'h0000000, 1'b1, 1'b0}};
      tv[12] = '{32'h7FC00000, 32'h3F800000, 1'b0, '{1'b0, 8'hFF, 28'h0000000, 1'b1, 1'b1}};
      bp[0] = 32'h3F800000;
      bp[1] = 32'h40400000;
      bp[2] = 32'h41200000;
      clrn = 1'b1;
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.sub = 1'b0;
      bus.out_ready = 1'b1;
      #1 clrn = 1'b0;
      #2;
      chk("rst out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst outputs", 64'({bus.out_sign, bus.out_exp, bus.out_mant, bus.out_special, bus.out_nan}), 64'd0);
      @(negedge clk);
      #2 clrn = 1'b1;
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         bus.a = tv[i].a;
         bus.b = tv[i].b;
         bus.sub = tv[i].sub;
         bus.in_valid = 1'b1;
         #1 chk("vec in_ready", 64'(bus.in_ready), 64'd1);
         @(posedge clk);
         #1 bus.in_valid = 1'b0;
         @(negedge clk);
         chk($sformatf("vec%0d lat1", i), 64'(bus.out_valid), 64'd0);
         @(negedge clk);
         chk($sformatf("vec%0d lat2", i), 64'(bus.out_valid), 64'd1);
         check_out($sformatf("vec%0d", i), tv[i].r);
      end
      // backpressure: three pairs offered against a stalled sink
      @(negedge clk);
      bus.out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 5; c++) begin
         bus.in_valid = idx < 3;
         if (idx < 3) begin bus.a = bp[idx]; bus.b = 32'h3F800000; bus.sub = 1'b0; end
         tick(acc);
         if (acc) idx++;
      end
      chk("bp accepts", 64'(idx), 64'd2);
      chk("bp in_ready", 64'(bus.in_ready), 64'd0);
      bus.out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         bus.in_valid = idx < 3;
         if (idx < 3) begin bus.a = bp[idx]; bus.b = 32'h3F800000; bus.sub = 1'b0; end
         tick(acc);
         if (acc) idx++;
      end
      chk("bp drained", 64'(idx == 3 && q.size() == 0), 64'd1);
      // reset with both stages occupied
      bus.out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         bus.in_valid = 1'b1;
         bus.a = 32'h40000000;
         bus.b = 32'h3F800000;
         tick(acc);
      end
      chk("pre-rst full", 64'({bus.out_valid, bus.in_ready}), 64'b10);
      #2 clrn = 1'b0;
      #1;
      chk("midrst out_valid", 64'(bus.out_valid), 64'd0);
      chk("midrst in_ready", 64'(bus.in_ready), 64'd1);
      chk("midrst outputs", 64'({bus.out_sign, bus.out_exp, bus.out_mant, bus.out_special, bus.out_nan}), 64'd0);
      q.delete();
      hold = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      clrn = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick(acc);
         chk("post-rst idle", 64'(bus.out_valid), 64'd0);
      end
      // randomized streaming against the reference model
      for (int c = 0; c < 4000; c++) begin
         bus.in_valid = $urandom_range(0, 3) != 0;
         bus.out_ready = $urandom_range(0, 3) != 0;
         bus.a = rnd_op(8'($urandom));
         bus.b = ($urandom_range(0, 15) == 0) ? bus.a : rnd_op(bus.a[30:23]);
         bus.sub = 1'($urandom);
         tick(acc);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 6; c++) tick(acc);
      chk("final drain", 64'(q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
